// File: rtl/adc_frame_rx.sv
// -----------------------------------------------------------------------------
// adc_frame_rx
//
// Frame initiator and receiver for a pair of dual-channel serial ADCs
// (AD7352-style) that share one active-low chip select. Each frame captures
// four parallel samples: vcap, icap, vout and iout.
//
// The converter SCLK is the system clock. The converters launch data on the
// falling edge and this block samples on the rising edge.
//
// Frame layout (ad_cs low for DATA_BITS+1 cycles, c = 0..DATA_BITS):
//   c = 0              leading-zero bit on every lane; any 1 flags the frame
//   c = 1..DATA_BITS   sample bits, MSB first
// ad_cs is then held high for GAP_CYCLES cycles before the next frame.
//
// Parameters:
//   DATA_BITS   sample width (>= 2)
//   GAP_CYCLES  cycles ad_cs stays high between frames (>= 1)
//   FREE_RUN    1: frames repeat back to back and start is ignored
//
// Ports:
//   clk         system clock, also the converter SCLK
//   reset_n     asynchronous reset, active low
//   start       frame request, level-sampled when not busy
//   ad_cs       converter chip select, active low
//   ad_sdata_a  [1] = vout lane, [0] = iout lane
//   ad_sdata_b  [1] = vcap lane, [0] = icap lane
//   busy        high from frame accept until the gap completes
//   valid       one-cycle pulse when the sample outputs are updated
//   vcap/icap/vout/iout  captured codes (raw straight binary), held between frames
//   frame_err   qualified by valid: a leading-zero bit was nonzero on some lane
// -----------------------------------------------------------------------------
module adc_frame_rx #(
    parameter int unsigned DATA_BITS  = 12,
    parameter int unsigned GAP_CYCLES = 2,
    parameter int unsigned FREE_RUN   = 0
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 start,
    output logic                 ad_cs,
    input  logic [1:0]           ad_sdata_a,
    input  logic [1:0]           ad_sdata_b,
    output logic                 busy,
    output logic                 valid,
    output logic [DATA_BITS-1:0] vcap,
    output logic [DATA_BITS-1:0] icap,
    output logic [DATA_BITS-1:0] vout,
    output logic [DATA_BITS-1:0] iout,
    output logic                 frame_err
);

    localparam int unsigned CntW = $clog2(DATA_BITS + 1);
    localparam int unsigned GapW = $clog2(GAP_CYCLES + 1);

    localparam logic [CntW-1:0] BitLast = CntW'(DATA_BITS);
    localparam logic [GapW-1:0] GapLast = GapW'(GAP_CYCLES - 1);
    localparam logic            FreeRun = (FREE_RUN != 0);

    typedef enum logic [1:0] {
        StIdle,
        StConv,
        StGap
    } state_t;

    state_t              state_q;
    logic [CntW-1:0]     bit_cnt_q;
    logic [GapW-1:0]     gap_cnt_q;
    logic                err_acc_q;
    logic [DATA_BITS-1:0] sh_vcap_q;
    logic [DATA_BITS-1:0] sh_icap_q;
    logic [DATA_BITS-1:0] sh_vout_q;
    logic [DATA_BITS-1:0] sh_iout_q;

    // Shift registers with the current lane bit appended; used both for the
    // per-cycle shift and for the final load on the last bit of the frame.
    logic [DATA_BITS-1:0] sh_vcap_nxt;
    logic [DATA_BITS-1:0] sh_icap_nxt;
    logic [DATA_BITS-1:0] sh_vout_nxt;
    logic [DATA_BITS-1:0] sh_iout_nxt;

    logic gap_done;
    logic launch;

    always_comb begin
        sh_vcap_nxt = {sh_vcap_q[DATA_BITS-2:0], ad_sdata_b[1]};
        sh_icap_nxt = {sh_icap_q[DATA_BITS-2:0], ad_sdata_b[0]};
        sh_vout_nxt = {sh_vout_q[DATA_BITS-2:0], ad_sdata_a[1]};
        sh_iout_nxt = {sh_iout_q[DATA_BITS-2:0], ad_sdata_a[0]};
    end

    // In free-run mode IDLE only exists after reset and times out one full
    // gap before the first frame. The edge that completes a gap also samples
    // start, so a held start gives exactly GAP_CYCLES of ad_cs high between
    // frames; start seen on any earlier gap edge is dropped.
    always_comb begin
        gap_done = (gap_cnt_q == GapLast);
        launch   = 1'b0;
        unique case (state_q)
            StIdle:  launch = FreeRun ? gap_done : start;
            StGap:   launch = gap_done && (FreeRun || start);
            default: launch = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= StIdle;
            bit_cnt_q <= '0;
            gap_cnt_q <= '0;
            err_acc_q <= 1'b0;
            sh_vcap_q <= '0;
            sh_icap_q <= '0;
            sh_vout_q <= '0;
            sh_iout_q <= '0;
            ad_cs     <= 1'b1;
            busy      <= 1'b0;
            valid     <= 1'b0;
            frame_err <= 1'b0;
            vcap      <= '0;
            icap      <= '0;
            vout      <= '0;
            iout      <= '0;
        end else begin
            valid <= 1'b0;

            unique case (state_q)
                StIdle: begin
                    if (FreeRun && !gap_done) begin
                        gap_cnt_q <= gap_cnt_q + GapW'(1);
                    end
                end

                StConv: begin
                    if (bit_cnt_q == '0) begin
                        // Leading bit of every lane must be zero.
                        err_acc_q <= err_acc_q | (|ad_sdata_a) | (|ad_sdata_b);
                    end else begin
                        sh_vcap_q <= sh_vcap_nxt;
                        sh_icap_q <= sh_icap_nxt;
                        sh_vout_q <= sh_vout_nxt;
                        sh_iout_q <= sh_iout_nxt;
                    end

                    if (bit_cnt_q == BitLast) begin
                        ad_cs     <= 1'b1;
                        vcap      <= sh_vcap_nxt;
                        icap      <= sh_icap_nxt;
                        vout      <= sh_vout_nxt;
                        iout      <= sh_iout_nxt;
                        frame_err <= err_acc_q;
                        valid     <= 1'b1;
                        gap_cnt_q <= '0;
                        state_q   <= StGap;
                    end else begin
                        bit_cnt_q <= bit_cnt_q + CntW'(1);
                    end
                end

                StGap: begin
                    if (gap_done) begin
                        gap_cnt_q <= '0;
                        err_acc_q <= 1'b0;
                        busy      <= 1'b0;
                        state_q   <= StIdle;
                    end else begin
                        gap_cnt_q <= gap_cnt_q + GapW'(1);
                    end
                end

                default: begin
                    ad_cs   <= 1'b1;
                    busy    <= 1'b0;
                    state_q <= StIdle;
                end
            endcase

            // Frame launch overrides the IDLE/GAP bookkeeping above.
            if (launch) begin
                state_q   <= StConv;
                bit_cnt_q <= '0;
                gap_cnt_q <= '0;
                err_acc_q <= 1'b0;
                ad_cs     <= 1'b0;
                busy      <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_adc_frame_rx.sv
// -----------------------------------------------------------------------------
// tb_adc_frame_rx
//
// Two instances: index 0 is start-driven (FREE_RUN=0), index 1 free-runs.
// A behavioural converter model per instance launches one zero bit plus 12
// data bits on the falling edge while ad_cs is low, and pushes the expected
// sample set into a scoreboard queue once the whole frame has been shifted
// out. A monitor per instance pops and compares on every valid pulse.
// -----------------------------------------------------------------------------
module tb_adc_frame_rx;

    localparam int unsigned Gap = 2;

    typedef struct packed {
        logic [11:0] vcap;
        logic [11:0] icap;
        logic [11:0] vout;
        logic [11:0] iout;
        logic [3:0]  lead;   // leading bits: {vcap, icap, vout, iout}
    } frm_t;

    logic        clk;
    logic        rst_n [2];
    logic        start;
    logic        start_fr;
    logic        cs    [2];
    logic [1:0]  sd_a  [2];
    logic [1:0]  sd_b  [2];
    logic        busy  [2];
    logic        vld   [2];
    logic [11:0] vcap  [2];
    logic [11:0] icap  [2];
    logic [11:0] vout  [2];
    logic [11:0] iout  [2];
    logic        ferr  [2];

    frm_t        code_q [2][$];
    logic [48:0] exp_q  [2][$];

    int checks;
    int errors;
    int cyc;
    int vcnt       [2];
    int last_v     [2];
    bit chk_period [2];

    adc_frame_rx #(.DATA_BITS(12), .GAP_CYCLES(Gap), .FREE_RUN(0)) u_dut0 (
        .clk        (clk),
        .reset_n    (rst_n[0]),
        .start      (start),
        .ad_cs      (cs[0]),
        .ad_sdata_a (sd_a[0]),
        .ad_sdata_b (sd_b[0]),
        .busy       (busy[0]),
        .valid      (vld[0]),
        .vcap       (vcap[0]),
        .icap       (icap[0]),
        .vout       (vout[0]),
        .iout       (iout[0]),
        .frame_err  (ferr[0])
    );

    adc_frame_rx #(.DATA_BITS(12), .GAP_CYCLES(Gap), .FREE_RUN(1)) u_dut1 (
        .clk        (clk),
        .reset_n    (rst_n[1]),
        .start      (start_fr),
        .ad_cs      (cs[1]),
        .ad_sdata_a (sd_a[1]),
        .ad_sdata_b (sd_b[1]),
        .busy       (busy[1]),
        .valid      (vld[1]),
        .vcap       (vcap[1]),
        .icap       (icap[1]),
        .vout       (vout[1]),
        .iout       (iout[1]),
        .frame_err  (ferr[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        cyc = 0;
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    function automatic frm_t rand_frame(input logic [3:0] lead);
        frm_t f;
        f.vcap = 12'($urandom);
        f.icap = 12'($urandom);
        f.vout = 12'($urandom);
        f.iout = 12'($urandom);
        f.lead = lead;
        return f;
    endfunction

    function automatic frm_t mk_frame(input logic [11:0] vc, input logic [11:0] ic,
                                      input logic [11:0] vo, input logic [11:0] io,
                                      input logic [3:0] lead);
        frm_t f;
        f.vcap = vc;
        f.icap = ic;
        f.vout = vo;
        f.iout = io;
        f.lead = lead;
        return f;
    endfunction

    // Converter model and scoreboard monitor, one pair per instance.
    for (genvar g = 0; g < 2; g++) begin : g_inst
        initial begin
            int   k;
            frm_t f;
            k = 0;
            f = '0;
            sd_a[g] = 2'($urandom);
            sd_b[g] = 2'($urandom);
            forever begin
                @(negedge clk);
                if (cs[g] !== 1'b0) begin
                    k = 0;
                    sd_a[g] = 2'($urandom);
                    sd_b[g] = 2'($urandom);
                end else begin
                    if (k == 0) begin
                        if (code_q[g].size() > 0) f = code_q[g].pop_front();
                        else f = rand_frame(4'b0000);
                        {sd_b[g], sd_a[g]} = f.lead;
                    end else if (k <= 12) begin
                        sd_b[g] = {f.vcap[12-k], f.icap[12-k]};
                        sd_a[g] = {f.vout[12-k], f.iout[12-k]};
                        if (k == 12) exp_q[g].push_back({f.vcap, f.icap, f.vout, f.iout, |f.lead});
                    end else begin
                        sd_a[g] = 2'($urandom);
                        sd_b[g] = 2'($urandom);
                    end
                    k++;
                end
            end
        end

        initial begin
            logic [48:0] e;
            forever begin
                @(posedge clk);
                #1;
                if (vld[g] === 1'b1) begin
                    vcnt[g]++;
                    check($sformatf("inst%0d_valid_has_expected", g), exp_q[g].size() > 0, 1);
                    check($sformatf("inst%0d_busy_at_valid", g), busy[g], 1);
                    if (exp_q[g].size() > 0) begin
                        e = exp_q[g].pop_front();
                        check($sformatf("inst%0d_frame%0d", g, vcnt[g]),
                              {vcap[g], icap[g], vout[g], iout[g], ferr[g]}, e);
                    end
                    if (chk_period[g] && last_v[g] >= 0)
                        check($sformatf("inst%0d_period", g), cyc - last_v[g], 13 + Gap);
                    last_v[g] = cyc;
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic accept_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic measure_low(output int n);
        n = 0;
        while (cs[0] === 1'b0 && n < 40) begin
            n++;
            step();
        end
    endtask

    task automatic measure_high(output int n);
        n = 0;
        while (cs[0] === 1'b1 && n < 40) begin
            n++;
            step();
        end
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (busy[0] !== 1'b0 && n < 100) begin
            n++;
            step();
        end
        check(name, busy[0], 0);
    endtask

    initial begin
        int n;
        int base;
        logic [11:0] r;

        checks = 0;
        errors = 0;
        vcnt = '{0, 0};
        last_v = '{-1, -1};
        chk_period = '{1'b0, 1'b1};
        start = 1'b0;
        start_fr = 1'b0;
        rst_n[0] = 1'b0;
        rst_n[1] = 1'b0;

        // Ramp codes for the free-running instance.
        for (int i = 0; i < 12; i++) begin
            r = 12'(i * 'h111);
            code_q[1].push_back(mk_frame(r, r ^ 12'hFFF, r + 12'd1, r + 12'd2, 4'b0000));
        end

        // Reset state
        #12;
        check("rst_cs", cs[0], 1);
        check("rst_busy", busy[0], 0);
        check("rst_valid", vld[0], 0);
        check("rst_ferr", ferr[0], 0);
        check("rst_samples", {vcap[0], icap[0], vout[0], iout[0]}, 0);
        check("rst_cs_fr", cs[1], 1);
        @(negedge clk);
        rst_n[0] = 1'b1;
        rst_n[1] = 1'b1;
        step();

        // Single frame: timing and exact codes
        code_q[0].push_back(mk_frame(12'hA00, 12'h200, 12'h050, 12'h1FF, 4'b0000));
        accept_start();
        measure_low(n);
        check("t1_cs_low_cycles", n, 13);
        check("t1_valid_latency", vld[0], 1);
        wait_idle("t1_idle");

        // Back-to-back frames with start held high
        code_q[0].push_back(mk_frame(12'hFFF, 12'h000, 12'hAAA, 12'h555, 4'b0000));
        code_q[0].push_back(mk_frame(12'h000, 12'hFFF, 12'h555, 12'hAAA, 4'b0000));
        code_q[0].push_back(mk_frame(12'hAAA, 12'h555, 12'hFFF, 12'h000, 4'b0000));
        start = 1'b1;
        step();
        for (int i = 0; i < 3; i++) begin
            measure_low(n);
            check($sformatf("t2_cs_low_%0d", i), n, 13);
            if (i == 2) start = 1'b0;
            else begin
                measure_high(n);
                check($sformatf("t2_cs_gap_%0d", i), n, Gap);
            end
        end
        wait_idle("t2_idle");

        // Lead-bit error on icap only, then a clean frame
        code_q[0].push_back(rand_frame(4'b0100));
        code_q[0].push_back(rand_frame(4'b0000));
        for (int i = 0; i < 2; i++) begin
            accept_start();
            measure_low(n);
            check($sformatf("t3_cs_low_%0d", i), n, 13);
            wait_idle("t3_idle");
        end

        // start pulses during CONV and GAP are dropped
        base = vcnt[0];
        code_q[0].push_back(rand_frame(4'b0000));
        accept_start();
        repeat (4) step();
        start = 1'b1;
        step();
        start = 1'b0;
        check("t4_busy_conv", busy[0], 1);
        measure_low(n);
        check("t4_cs_low_rest", n, 8);
        check("t4_valid", vld[0], 1);
        start = 1'b1;
        step();
        start = 1'b0;
        check("t4_busy_gap", busy[0], 1);
        check("t4_cs_gap", cs[0], 1);
        step();
        check("t4_busy_after_gap", busy[0], 0);
        step();
        check("t4_cs_no_restart", cs[0], 1);
        repeat (3) step();
        check("t4_one_valid", vcnt[0] - base, 1);

        // Reset in the middle of a frame
        base = vcnt[0];
        code_q[0].push_back(rand_frame(4'b0000));
        accept_start();
        repeat (6) step();
        rst_n[0] = 1'b0;
        #1;
        check("t5_cs_async", cs[0], 1);
        check("t5_busy", busy[0], 0);
        check("t5_valid", vld[0], 0);
        check("t5_samples", {vcap[0], icap[0], vout[0], iout[0], ferr[0]}, 0);
        repeat (3) step();
        @(negedge clk);
        rst_n[0] = 1'b1;
        step();
        check("t5_no_valid", vcnt[0] - base, 0);
        code_q[0].push_back(rand_frame(4'b0000));
        accept_start();
        measure_low(n);
        check("t5_cs_low_after_reset", n, 13);
        wait_idle("t5_idle");

        // Randomized frames with occasional lead-bit errors and idle gaps
        for (int i = 0; i < 20; i++) begin
            code_q[0].push_back(rand_frame(($urandom % 4 == 0) ? 4'($urandom) : 4'b0000));
            accept_start();
            wait_idle("rnd_idle");
            repeat ($urandom_range(0, 3)) step();
        end

        // Free-running instance has been producing frames throughout
        n = 0;
        while (vcnt[1] < 10 && n < 400) begin
            n++;
            step();
        end
        check("fr_frame_count", vcnt[1] >= 10, 1);

        repeat (5) step();
        check("pending_expected_inst0", exp_q[0].size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
